// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory arbiter.
package mem_arb_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // Requester identity; also used as the round-robin history bit.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    // Byte address -> word index shift.
    localparam int WORD_SHIFT = 2;

    // True when a word index lies beyond the implemented memory.
    function automatic logic word_out_of_range(input logic [63:0] word_idx,
                                               input logic [63:0] mem_words);
        return word_idx >= mem_words;
    endfunction

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Combinational two-way round-robin picker for the memory arbiter.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,         // bit 0: CPU, bit 1: loader
    input  owner_t     last_owner,
    input  logic       mask,        // suppresses the CPU request (load mode)
    output logic       grant_valid,
    output owner_t     grant_owner
);

    logic cpu_elig;
    logic ldr_elig;

    assign cpu_elig = req[0] & ~mask;
    assign ldr_elig = req[1];

    // Pick the sole eligible requester, or alternate against last_owner on a tie.
    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OWN_CPU;
        case ({ldr_elig, cpu_elig})
            2'b01: begin
                grant_valid = 1'b1;
                grant_owner = OWN_CPU;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_owner = OWN_LDR;
            end
            2'b11: begin
                grant_valid = 1'b1;
                if (last_owner == OWN_CPU) grant_owner = OWN_LDR;
                else                       grant_owner = OWN_CPU;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-ported unified memory between the CPU and the
// program loader. Each access runs IDLE -> ACCESS -> WAIT x MEM_LAT -> RESP.
//
// Handshake: a requester raises req with stable inputs and holds them until
// its ack pulse; on the edge closing the ack cycle it drops req or presents
// the next request. Requests are sampled only in IDLE, so nothing asserted
// mid-access is lost; it is simply seen at the next arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int MEM_WORDS = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [ADDR_W-1:0]          cpu_addr,
    input  logic [DATA_W-1:0]          cpu_wdata,
    output logic [DATA_W-1:0]          cpu_rdata,
    output logic                       cpu_ack,
    output logic                       cpu_stall,
    input  logic                       ldr_req,
    input  logic                       ldr_we,
    input  logic [ADDR_W-1:0]          ldr_addr,
    input  logic [DATA_W-1:0]          ldr_wdata,
    output logic [DATA_W-1:0]          ldr_rdata,
    output logic                       ldr_ack,
    input  logic                       ldr_lock,
    output logic                       err,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-WORD_SHIFT-1:0] mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output arb_state_t                 dbg_state
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WA_W  = ADDR_W - WORD_SHIFT;

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    owner_t            last_owner_q;
    owner_t            owner_q;
    logic              we_q;
    logic              bad_q;
    logic [WA_W-1:0]   waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ldr_rdata_q;

    logic              grant_valid;
    owner_t            grant_owner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;
    logic [DATA_W-1:0] rdata_capture;
    logic              unused_addr_lsbs;

    rr_arb2 u_rr_arb2 (
        .req         ({ldr_req, cpu_req}),
        .last_owner  (last_owner_q),
        .mask        (ldr_lock),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Byte-lane bits are irrelevant to a word-wide memory.
    assign unused_addr_lsbs = ^{cpu_addr[WORD_SHIFT-1:0], ldr_addr[WORD_SHIFT-1:0]};

    assign sel_we    = (grant_owner == OWN_LDR) ? ldr_we    : cpu_we;
    assign sel_addr  = (grant_owner == OWN_LDR) ? ldr_addr  : cpu_addr;
    assign sel_wdata = (grant_owner == OWN_LDR) ? ldr_wdata : cpu_wdata;
    assign sel_bad   = word_out_of_range(64'(sel_addr[ADDR_W-1:WORD_SHIFT]), 64'(MEM_WORDS));

    // Writes and out-of-range accesses return zero read data.
    assign rdata_capture = (bad_q || we_q) ? '0 : mem_rdata;

    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign dbg_state = state_q;

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus the per-state memory strobes and completion pulses.
    always_comb begin
        state_d = state_q;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        cpu_ack = 1'b0;
        ldr_ack = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) state_d = ACCESS;
            end
            ACCESS: begin
                mem_en  = ~bad_q;
                mem_we  = ~bad_q & we_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
            end
            RESP: begin
                cpu_ack = (owner_q == OWN_CPU);
                ldr_ack = (owner_q == OWN_LDR);
                err     = bad_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latches, latency counter and per-owner read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            last_owner_q <= OWN_LDR;
            owner_q      <= OWN_CPU;
            we_q         <= 1'b0;
            bad_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q      <= grant_owner;
                        last_owner_q <= grant_owner;
                        we_q         <= sel_we;
                        waddr_q      <= sel_addr[ADDR_W-1:WORD_SHIFT];
                        wdata_q      <= sel_wdata;
                        bad_q        <= sel_bad;
                    end
                end
                ACCESS: begin
                    cnt_q <= CNT_W'(MEM_LAT - 1);
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (owner_q == OWN_CPU) cpu_rdata_q <= rdata_capture;
                        else                    ldr_rdata_q <= rdata_capture;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
